// File: rtl/hamming_read_ctrl.sv
// hamming_read_ctrl
// Pops 12-bit Hamming words from a source FIFO, presents each one to an
// external combinational decoder, and delivers the corrected byte over a
// valid/ready interface. Counts words with a nonzero syndrome (saturating)
// and delivered words (wrapping).
//
// Ports
//   Clk         system clock, rising edge
//   Reset       asynchronous, active-low reset
//   Enable      level, 1 permits new FIFO fetches
//   Fifo_Empty  source FIFO empty flag
//   Fifo_Read   one-cycle FIFO pop strobe (high during FETCH)
//   Fifo_Data   Hamming word, captured while Fifo_Read is high
//   Ham_Word    registered word driven to the external decoder
//   Dec_Data    corrected byte from the decoder (combinational from Ham_Word)
//   Dec_Syn_Nz  decoder syndrome nonzero (combinational from Ham_Word)
//   Out_Data    delivered byte
//   Out_Valid   Out_Data valid
//   Out_Ready   downstream accepts
//   Err_Clr     synchronous clear of Err_Cnt / Err_Flag
//   Err_Cnt     saturating count of words with nonzero syndrome
//   Err_Flag    sticky nonzero-syndrome flag
//   Word_Cnt    wrapping count of delivered words
//   Busy        1 in every state except IDLE
module hamming_read_ctrl #(
  parameter int unsigned ERR_CNT_W  = 8,
  parameter int unsigned WORD_CNT_W = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Enable,
  input  logic                  Fifo_Empty,
  output logic                  Fifo_Read,
  input  logic [11:0]           Fifo_Data,
  output logic [11:0]           Ham_Word,
  input  logic [7:0]            Dec_Data,
  input  logic                  Dec_Syn_Nz,
  output logic [7:0]            Out_Data,
  output logic                  Out_Valid,
  input  logic                  Out_Ready,
  input  logic                  Err_Clr,
  output logic [ERR_CNT_W-1:0]  Err_Cnt,
  output logic                  Err_Flag,
  output logic [WORD_CNT_W-1:0] Word_Cnt,
  output logic                  Busy
);

  localparam int unsigned HAM_W  = 12;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DECODE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t                state_q,     state_d;
  logic                  fifo_read_q, fifo_read_d;
  logic [HAM_W-1:0]      ham_word_q,  ham_word_d;
  logic [BYTE_W-1:0]     out_data_q,  out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic [ERR_CNT_W-1:0]  err_cnt_q,   err_cnt_d;
  logic                  err_flag_q,  err_flag_d;
  logic [WORD_CNT_W-1:0] word_cnt_q,  word_cnt_d;
  logic                  busy_q,      busy_d;

  logic handshake;
  logic fetch_ok;

  assign handshake = out_valid_q & Out_Ready;
  assign fetch_ok  = Enable & ~Fifo_Empty;

  // State and output registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      fifo_read_q <= 1'b0;
      ham_word_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_cnt_q   <= '0;
      err_flag_q  <= 1'b0;
      word_cnt_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fifo_read_q <= fifo_read_d;
      ham_word_q  <= ham_word_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_cnt_q   <= err_cnt_d;
      err_flag_q  <= err_flag_d;
      word_cnt_q  <= word_cnt_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    fifo_read_d = 1'b0;
    ham_word_d  = ham_word_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    err_cnt_d   = err_cnt_q;
    err_flag_d  = err_flag_q;
    word_cnt_d  = word_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (fetch_ok) begin
          fifo_read_d = 1'b1;
          state_d     = FETCH;
        end
      end

      // The pop strobe is high this cycle; the FIFO head is on Fifo_Data.
      FETCH: begin
        ham_word_d = Fifo_Data;
        state_d    = DECODE;
      end

      DECODE: begin
        out_data_d  = Dec_Data;
        out_valid_d = 1'b1;
        if (Dec_Syn_Nz) begin
          err_flag_d = 1'b1;
          if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
          end
        end
        state_d = HOLD;
      end

      // Out_* hold until accepted; the next fetch is chained off the handshake.
      HOLD: begin
        if (handshake) begin
          word_cnt_d  = word_cnt_q + WORD_CNT_W'(1);
          out_valid_d = 1'b0;
          if (fetch_ok) begin
            fifo_read_d = 1'b1;
            state_d     = FETCH;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Clear has priority over a same-cycle increment.
    if (Err_Clr) begin
      err_cnt_d  = '0;
      err_flag_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  assign Fifo_Read = fifo_read_q;
  assign Ham_Word  = ham_word_q;
  assign Out_Data  = out_data_q;
  assign Out_Valid = out_valid_q;
  assign Err_Cnt   = err_cnt_q;
  assign Err_Flag  = err_flag_q;
  assign Word_Cnt  = word_cnt_q;
  assign Busy      = busy_q;

endmodule

// File: tb/tb_hamming_read_ctrl.sv
// Bench for hamming_read_ctrl: FIFO model, toy decoder, byte scoreboard.
// A second instance with 2-bit counters checks saturation and wrap.
module tb_hamming_read_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        enable;
  logic        out_ready;
  logic        err_clr;
  logic        fifo_empty;
  logic [11:0] fifo_data;

  logic        fifo_read, out_valid, err_flag, busy, dec_syn;
  logic [11:0] ham_word;
  logic [7:0]  out_data, dec_data;
  logic [7:0]  err_cnt;
  logic [15:0] word_cnt;

  logic        s_fifo_read, s_out_valid, s_err_flag, s_busy, s_dec_syn;
  logic [11:0] s_ham_word;
  logic [7:0]  s_out_data, s_dec_data;
  logic [1:0]  s_err_cnt;
  logic [1:0]  s_word_cnt;

  // Toy decoder: byte is low 8 bits XOR 0x5A, syndrome flag is bit 11.
  assign dec_data   = ham_word[7:0] ^ 8'h5A;
  assign dec_syn    = ham_word[11];
  assign s_dec_data = s_ham_word[7:0] ^ 8'h5A;
  assign s_dec_syn  = s_ham_word[11];

  hamming_read_ctrl u_dut (
    .Clk(clk), .Reset(rst_n), .Enable(enable), .Fifo_Empty(fifo_empty),
    .Fifo_Read(fifo_read), .Fifo_Data(fifo_data), .Ham_Word(ham_word),
    .Dec_Data(dec_data), .Dec_Syn_Nz(dec_syn), .Out_Data(out_data),
    .Out_Valid(out_valid), .Out_Ready(out_ready), .Err_Clr(err_clr),
    .Err_Cnt(err_cnt), .Err_Flag(err_flag), .Word_Cnt(word_cnt), .Busy(busy)
  );

  hamming_read_ctrl #(.ERR_CNT_W(2), .WORD_CNT_W(2)) u_small (
    .Clk(clk), .Reset(rst_n), .Enable(enable), .Fifo_Empty(fifo_empty),
    .Fifo_Read(s_fifo_read), .Fifo_Data(fifo_data), .Ham_Word(s_ham_word),
    .Dec_Data(s_dec_data), .Dec_Syn_Nz(s_dec_syn), .Out_Data(s_out_data),
    .Out_Valid(s_out_valid), .Out_Ready(out_ready), .Err_Clr(err_clr),
    .Err_Cnt(s_err_cnt), .Err_Flag(s_err_flag), .Word_Cnt(s_word_cnt), .Busy(s_busy)
  );

  // Source FIFO: head shown on Fifo_Data, popped on a clock edge with Fifo_Read.
  logic [11:0] mem [256];
  logic [7:0]  wr_ptr = 8'd0;
  logic [7:0]  rd_ptr = 8'd0;
  always @(posedge clk) if (fifo_read && rd_ptr != wr_ptr) rd_ptr <= rd_ptr + 8'd1;
  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_data  = mem[rd_ptr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_q [$];
  logic [7:0] sb_exp;

  // Scoreboard: every accepted byte must match the oldest expected byte.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_extra: got byte %h, expected none", out_data);
      end else begin
        sb_exp = exp_q.pop_front();
        if (out_data !== sb_exp) begin
          miscompares++;
          $display("FAIL sb_byte: got %h, expected %h", out_data, sb_exp);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic push_word(input logic [7:0] b, input logic syn);
    mem[wr_ptr] = {syn, 3'b101, b ^ 8'h5A};
    wr_ptr      = wr_ptr + 8'd1;
    exp_q.push_back(b);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_read(input string tag);
    bit found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      if (fifo_read) found = 1;
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL %s: got no Fifo_Read, expected one", tag); end
  endtask

  task automatic wait_words(input string tag, input logic [15:0] n);
    bit found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (word_cnt == n) found = 1;
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL %s: got Word_Cnt %0d, expected %0d", tag, word_cnt, n); end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    vectors++;
    if ({fifo_read, out_valid, busy, err_flag} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ctl: got rd/vld/busy/flag %b, expected 0000", {fifo_read, out_valid, busy, err_flag});
    end
    vectors++;
    if ({out_data, ham_word, err_cnt, word_cnt} !== 44'd0) begin
      miscompares++;
      $display("FAIL reset_data: got %h, expected 0", {out_data, ham_word, err_cnt, word_cnt});
    end
  endtask

  task automatic test_single();
    int t;
    do_reset();
    enable = 1'b1; out_ready = 1'b1;
    push_word(8'hA5, 1'b0);
    wait_read("single_read");
    t = cyc;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_t1: got Out_Valid %b, expected 0", out_valid); end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || cyc - t != 2) begin
      miscompares++;
      $display("FAIL single_t2: got vld %b data %h after %0d, expected 1 a5 after 2", out_valid, out_data, cyc - t);
    end
    @(negedge clk);
    vectors++;
    if (word_cnt !== 16'd1 || err_cnt !== 8'd0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_end: got wc %0d ec %0d busy %b vld %b, expected 1 0 0 0", word_cnt, err_cnt, busy, out_valid);
    end
  endtask

  task automatic test_backpressure();
    bit found = 0;
    do_reset();
    enable = 1'b1; out_ready = 1'b0;
    push_word(8'h3C, 1'b0);
    push_word(8'hC3, 1'b0);
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      if (out_valid) found = 1;
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL bp_valid: got no Out_Valid, expected one"); end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 8'h3C || fifo_read !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold: cycle %0d got vld %b data %h rd %b, expected 1 3c 0", i, out_valid, out_data, fifo_read);
      end
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || fifo_read !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_hs: got vld %b rd %b, expected 1 0", out_valid, fifo_read);
    end
    @(negedge clk);
    vectors++;
    if (fifo_read !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_next_read: got rd %b vld %b busy %b, expected 1 0 1", fifo_read, out_valid, busy);
    end
    wait_words("bp_done", 16'd2);
  endtask

  task automatic test_corrected();
    int hs [4];
    int n = 0;
    do_reset();
    enable = 1'b1; out_ready = 1'b1;
    push_word(8'h11, 1'b1);
    push_word(8'h22, 1'b0);
    push_word(8'h33, 1'b1);
    push_word(8'h44, 1'b1);
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin hs[n] = cyc; n++; end
    end
    vectors++;
    if (n != 4) begin miscompares++; $display("FAIL corr_count: got %0d handshakes, expected 4", n); end
    else begin
      vectors++;
      if (hs[1] - hs[0] != 3 || hs[3] - hs[0] != 9) begin
        miscompares++;
        $display("FAIL throughput: got spacing %0d/%0d, expected 3/9", hs[1] - hs[0], hs[3] - hs[0]);
      end
    end
    @(negedge clk);
    vectors++;
    if (err_cnt !== 8'd3 || err_flag !== 1'b1 || word_cnt !== 16'd4) begin
      miscompares++;
      $display("FAIL corr_cnt: got ec %0d flag %b wc %0d, expected 3 1 4", err_cnt, err_flag, word_cnt);
    end
    vectors++;
    if (s_err_cnt !== 2'd3 || s_word_cnt !== 2'd0) begin
      miscompares++;
      $display("FAIL corr_small: got ec %0d wc %0d, expected 3 0", s_err_cnt, s_word_cnt);
    end
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    vectors++;
    if (err_cnt !== 8'd0 || err_flag !== 1'b0 || word_cnt !== 16'd4) begin
      miscompares++;
      $display("FAIL corr_clr: got ec %0d flag %b wc %0d, expected 0 0 4", err_cnt, err_flag, word_cnt);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    enable = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) push_word(8'(8'h0F + 8'(i) * 8'h11), 1'b1);
    wait_words("sat_done", 16'd5);
    vectors++;
    if (err_cnt !== 8'd5 || err_flag !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_wide: got ec %0d flag %b, expected 5 1", err_cnt, err_flag);
    end
    vectors++;
    if (s_err_cnt !== 2'd3 || s_word_cnt !== 2'd1 || s_err_flag !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_small: got ec %0d wc %0d flag %b, expected 3 1 1", s_err_cnt, s_word_cnt, s_err_flag);
    end
  endtask

  task automatic test_clr_collide();
    do_reset();
    enable = 1'b1; out_ready = 1'b1;
    push_word(8'h5A, 1'b1);
    wait_words("coll_pre", 16'd1);
    vectors++;
    if (err_cnt !== 8'd1) begin miscompares++; $display("FAIL coll_pre_cnt: got %0d, expected 1", err_cnt); end
    @(posedge clk); #1 push_word(8'h77, 1'b1);
    wait_read("coll_read");
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    vectors++;
    if (err_cnt !== 8'd0 || err_flag !== 1'b0 || s_err_cnt !== 2'd0) begin
      miscompares++;
      $display("FAIL coll_clr: got ec %0d flag %b sec %0d, expected 0 0 0", err_cnt, err_flag, s_err_cnt);
    end
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 8'h77) begin
      miscompares++;
      $display("FAIL coll_out: got vld %b data %h, expected 1 77", out_valid, out_data);
    end
    wait_words("coll_done", 16'd2);
    vectors++;
    if (err_cnt !== 8'd0) begin miscompares++; $display("FAIL coll_after: got %0d, expected 0", err_cnt); end
  endtask

  task automatic test_enable_drop();
    int reads = 0;
    do_reset();
    enable = 1'b1; out_ready = 1'b1;
    push_word(8'h81, 1'b0);
    push_word(8'h82, 1'b0);
    wait_read("en_read");
    @(posedge clk); #1 enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fifo_read) reads++;
    end
    vectors++;
    if (reads != 0 || word_cnt !== 16'd1 || busy !== 1'b0 || fifo_empty !== 1'b0) begin
      miscompares++;
      $display("FAIL en_drop: got reads %0d wc %0d busy %b empty %b, expected 0 1 0 0", reads, word_cnt, busy, fifo_empty);
    end
    @(posedge clk); #1 enable = 1'b1;
    wait_words("en_resume", 16'd2);
  endtask

  task automatic test_reset_hold();
    bit found = 0;
    int reads = 0;
    do_reset();
    enable = 1'b1; out_ready = 1'b1;
    push_word(8'hE1, 1'b1);
    wait_words("rh_pre", 16'd1);
    @(posedge clk); #1 out_ready = 1'b0;
    push_word(8'h3E, 1'b0);
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      if (out_valid) found = 1;
    end
    vectors++;
    if (!found || busy !== 1'b1 || ham_word !== {1'b0, 3'b101, 8'h3E ^ 8'h5A} || err_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL rh_hold: got vld %b busy %b hw %h ec %0d, expected 1 1 %h 1",
               out_valid, busy, ham_word, err_cnt, {1'b0, 3'b101, 8'h3E ^ 8'h5A});
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({out_valid, busy, fifo_read, err_flag} !== 4'b0000 || {out_data, ham_word, err_cnt, word_cnt} !== 44'd0) begin
      miscompares++;
      $display("FAIL rh_async: got ctl %b data %h, expected 0000 0",
               {out_valid, busy, fifo_read, err_flag}, {out_data, ham_word, err_cnt, word_cnt});
    end
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (fifo_read) reads++;
    end
    vectors++;
    if (reads != 0 || fifo_empty !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rh_after: got reads %0d empty %b busy %b, expected 0 1 0", reads, fifo_empty, busy);
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_corrected();
    test_saturation();
    test_clr_collide();
    test_enable_drop();
    test_reset_hold();
    @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL sb_leftover: got %0d bytes pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hamming_read_ctrl.md
HAMMING_READ_CTRL -- requirements
Module: hamming_read_ctrl

Interface
REQ-001 The block SHALL have parameter ERR_CNT_W, default 8, giving the width of the corrected-word error counter.
REQ-002 The block SHALL have parameter WORD_CNT_W, default 16, giving the width of the delivered-word counter.
REQ-003 The block SHALL have port Clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port Enable, input, 1 bit: level; 1 permits new FIFO fetches.
REQ-006 The block SHALL have port Fifo_Empty, input, 1 bit: source FIFO empty flag.
REQ-007 The block SHALL have port Fifo_Read, output, 1 bit: one-cycle FIFO pop strobe.
REQ-008 The block SHALL have port Fifo_Data, input, 12 bits: Hamming word, valid the cycle after Fifo_Read.
REQ-009 The block SHALL have port Ham_Word, output, 12 bits: registered word driven to the external decoder.
REQ-010 The block SHALL have port Dec_Data, input, 8 bits: corrected byte from the decoder, combinational from Ham_Word.
REQ-011 The block SHALL have port Dec_Syn_Nz, input, 1 bit: decoder syndrome nonzero, combinational from Ham_Word.
REQ-012 The block SHALL have port Out_Data, output, 8 bits: delivered byte.
REQ-013 The block SHALL have port Out_Valid, output, 1 bit: Out_Data valid.
REQ-014 The block SHALL have port Out_Ready, input, 1 bit: downstream accepts.
REQ-015 The block SHALL have port Err_Clr, input, 1 bit: synchronous clear of Err_Cnt and Err_Flag.
REQ-016 The block SHALL have port Err_Cnt, output, ERR_CNT_W bits: number of words with nonzero syndrome.
REQ-017 The block SHALL have port Err_Flag, output, 1 bit: sticky flag, set on any nonzero syndrome.
REQ-018 The block SHALL have port Word_Cnt, output, WORD_CNT_W bits: delivered-word count, wrapping.
REQ-019 The block SHALL have port Busy, output, 1 bit: 1 in every state except IDLE.

Function
REQ-020 The FSM SHALL have exactly the states IDLE, FETCH, DECODE and HOLD.
REQ-021 In IDLE with Enable=1 and Fifo_Empty=0, the block SHALL assert Fifo_Read for one cycle and go to FETCH.
REQ-022 Fifo_Read SHALL never be asserted while Fifo_Empty=1 or while Out_Valid=1 without a same-cycle handshake.
REQ-023 In FETCH, the block SHALL register Fifo_Data into Ham_Word and go to DECODE.
REQ-024 In DECODE, the block SHALL register Dec_Data into Out_Data, set Out_Valid=1, and go to HOLD.
REQ-025 In DECODE with Dec_Syn_Nz=1, the block SHALL set Err_Flag and increment Err_Cnt, saturating at all-ones.
REQ-026 In HOLD, Out_Data and Out_Valid SHALL stay stable until Out_Valid=1 and Out_Ready=1 in the same cycle.
REQ-027 On the HOLD handshake, the block SHALL increment Word_Cnt (mod 2^WORD_CNT_W) and clear Out_Valid.
REQ-028 On the HOLD handshake with Enable=1 and Fifo_Empty=0, the block SHALL assert Fifo_Read that cycle and go to FETCH; otherwise it SHALL go to IDLE.
REQ-029 Sustained throughput SHALL be one byte per 3 cycles when Out_Ready is held at 1.
REQ-030 Latency from the Fifo_Read strobe to Out_Valid=1 SHALL be 2 cycles.
REQ-031 Enable deasserting mid-word SHALL NOT abort the word; the word completes through HOLD, and the block then returns to IDLE.
REQ-032 When Err_Clr and a DECODE increment occur in the same cycle, clear SHALL win (Err_Cnt=0, Err_Flag=0).
REQ-033 Err_Clr SHALL NOT affect the FSM, Word_Cnt or Out_*.

Reset
REQ-034 On Reset=0, the block SHALL asynchronously force state=IDLE, Fifo_Read=0, Out_Valid=0, Out_Data=0, Ham_Word=0, Err_Cnt=0, Err_Flag=0, Word_Cnt=0 and Busy=0.
REQ-035 A reset asserted mid-word SHALL discard the word; the popped FIFO entry is not re-read.
REQ-036 After Reset release, the first Fifo_Read SHALL occur no earlier than the first rising Clk edge.

Verification
REQ-037 The bench SHALL cover the single-word case: FIFO holds one word, Dec_Data=0xA5, Dec_Syn_Nz=0, Enable=1, Out_Ready=1 -> Read at cycle t, Out_Valid at t+2 with 0xA5, Word_Cnt=1, Err_Cnt=0, then IDLE.
REQ-038 The bench SHALL cover backpressure: Out_Ready=0 for 5 cycles -> Out_Data stable, no Fifo_Read; handshake on cycle 6 -> next Read the same cycle.
REQ-039 The bench SHALL cover a corrected word: Dec_Syn_Nz=1 on 3 of 4 words -> Err_Cnt=3, Err_Flag=1; then Err_Clr -> 0/0 with Word_Cnt=4 unchanged.
REQ-040 The bench SHALL cover saturation and wrap: ERR_CNT_W=2 with 5 error words -> Err_Cnt=3; WORD_CNT_W=2 with 5 words -> Word_Cnt=1.
REQ-041 The bench SHALL cover Err_Clr coinciding with a DECODE increment -> Err_Cnt=0, Err_Flag=0.
REQ-042 The bench SHALL cover reset in HOLD: Reset=0 asynchronously -> Out_Valid=0, state IDLE, all counters 0 before the next Clk edge.
